// File: rtl/ser_out_rx.sv
// ser_out_rx: serial frame receiver for the chip's ser_out stream.
// Frame: start(0), DATA_W data bits LSB first, even parity, stop(1), one bit per ser_clk.
// Good words are buffered in a FIFO_DEPTH-entry FIFO with a valid/ready read port.
// Optional saturating error counter enabled by defining SER_RX_ERR_CNT_EN.
module ser_out_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              ser_clk,
  input  logic              reset_n,
  input  logic              ser_out,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              par_err,
  output logic              frame_err,
  output logic              overflow,
  output logic [7:0]        err_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {StIdle, StData, StPar, StStop, StBreak} state_e;

  state_e              state_q, state_d;
  logic                rx_s;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   shift;
  logic                par_bad;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;

  logic                last_bit;
  logic                good_word, par_hit, frame_hit, ovf_hit;
  logic                full, pop, do_push;

  assign last_bit = (bit_cnt == CW'(DATA_W - 1));
  assign full     = (count == (AW + 1)'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
  assign pop      = rx_valid && rx_ready;

  // State register
  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic; acts only on the registered line sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!rx_s) state_d = StData;
      StData:  if (last_bit) state_d = StPar;
      StPar:   state_d = StStop;
      StStop:  state_d = rx_s ? StIdle : StBreak;
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: frame outcome in STOP and the busy flag
  always_comb begin
    busy      = (state_q != StIdle);
    good_word = (state_q == StStop) && rx_s && !par_bad;
    par_hit   = (state_q == StStop) && rx_s && par_bad;
    frame_hit = (state_q == StStop) && !rx_s;
    // A simultaneous pop frees a slot, so a full FIFO only overflows without one
    ovf_hit   = good_word && full && !pop;
    do_push   = good_word && !ovf_hit;
  end

  // Line sampling, bit counting, data shifting and registered error pulses
  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s      <= 1'b1;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bad   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_s      <= ser_out;
      par_err   <= par_hit;
      frame_err <= frame_hit;
      overflow  <= ovf_hit;
      case (state_q)
        StIdle: bit_cnt <= '0;
        StData: begin
          shift[bit_cnt] <= rx_s;
          if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
        end
        StPar:  par_bad <= (^shift) ^ rx_s;
        default: ;
      endcase
    end
  end

  // Output FIFO: pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SER_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of cycles with any error pulse
  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if ((par_hit || frame_hit || ovf_hit) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
